// File: rtl/bloco_seq_pkg.sv
// Purpose: shared types and constants for the BLOCO sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package bloco_seq_pkg;

    localparam int END_REGISTROS = 2;
    localparam int BITS_OP       = 5;
    localparam int BITS_REP      = 4;
    localparam int NUM_OPS       = 20;
    localparam int INSTR_W       = 16;

    // Bit offsets of the instruction word fields.
    localparam int OFS_CLR  = 15;
    localparam int OFS_OP   = 10;
    localparam int OFS_DEST = 8;
    localparam int OFS_SRCA = 6;
    localparam int OFS_SRCB = 4;
    localparam int OFS_REP  = 0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        DONE   = 3'd3,
        CLR    = 3'd4
    } state_t;

    // Field order matches the word layout, MSB first.
    typedef struct packed {
        logic                     clr_flags;
        logic [BITS_OP-1:0]       op;
        logic [END_REGISTROS-1:0] dest;
        logic [END_REGISTROS-1:0] src_a;
        logic [END_REGISTROS-1:0] src_b;
        logic [BITS_REP-1:0]      rep;
    } instr_t;

endpackage

// File: rtl/bloco_seq_decode.sv
// Purpose: split an instruction word into fields and flag unknown opcodes.
// Latency: combinational.
// Backpressure: none; pure function of the input word.
module bloco_seq_decode
    import bloco_seq_pkg::*;
#(
    parameter int num_ops = NUM_OPS
) (
    input  logic [INSTR_W-1:0] instr_word,
    output instr_t             instr,
    output logic               illegal
);

    // One extra bit so num_ops up to 2**BITS_OP compares correctly.
    localparam logic [BITS_OP:0] NUM_OPS_W = (BITS_OP+1)'(num_ops);

    assign instr   = instr_t'(instr_word);
    assign illegal = ({1'b0, instr.op} >= NUM_OPS_W);

endmodule

// File: rtl/bloco_sequenciador.sv
// Purpose: multi-cycle controller driving BLOCO selects, opcode and write enable.
// Latency: accept at 0, decode 1, writes 2..2+rep, done at 3+rep (illegal op: done at 2).
// Backpressure: instr_ready only in IDLE without a pending clear_bank; word must be held.
module bloco_sequenciador
    import bloco_seq_pkg::*;
#(
    parameter int end_registros = END_REGISTROS,
    parameter int bits_op       = BITS_OP,
    parameter int bits_rep      = BITS_REP,
    parameter int num_ops       = NUM_OPS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [INSTR_W-1:0]       instr_word,
    input  logic                     clear_bank,
    output logic                     Hab_Escrita,
    output logic [end_registros-1:0] Sel_SA,
    output logic [end_registros-1:0] Sel_SB,
    output logic [end_registros-1:0] Sel_SC,
    output logic [bits_op-1:0]       controleOperacao,
    output logic                     reset_Flags,
    output logic                     reset_Ban_Registros,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    state_t                   state_q, state_d;
    logic [bits_rep-1:0]      rep_q, rep_d;
    logic                     illegal_q, illegal_d;
    logic                     hab_q, hab_d;
    logic [end_registros-1:0] sa_q, sa_d, sb_q, sb_d, sc_q, sc_d;
    logic [bits_op-1:0]       op_q, op_d;
    logic                     rf_q, rf_d;
    logic                     rb_q, rb_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    instr_t dec;
    logic   dec_illegal;

    bloco_seq_decode #(.num_ops(num_ops)) u_decode (
        .instr_word (instr_word),
        .instr      (dec),
        .illegal    (dec_illegal)
    );

    assign instr_ready         = (state_q == IDLE) && !clear_bank;
    assign busy                = (state_q != IDLE);
    assign Hab_Escrita         = hab_q;
    assign Sel_SA              = sa_q;
    assign Sel_SB              = sb_q;
    assign Sel_SC              = sc_q;
    assign controleOperacao    = op_q;
    assign reset_Flags         = rf_q;
    assign reset_Ban_Registros = rb_q;
    assign done                = done_q;
    assign err                 = err_q;

    // Next state plus the registered output values for the state being entered.
    always_comb begin
        state_d   = state_q;
        rep_d     = rep_q;
        illegal_d = illegal_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        sc_d      = sc_q;
        op_d      = op_q;
        hab_d     = 1'b0;
        rf_d      = 1'b0;
        rb_d      = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clear_bank) begin
                    state_d = CLR;
                    rb_d    = 1'b1;
                end else if (instr_valid) begin
                    state_d   = DECODE;
                    rep_d     = dec.rep;
                    illegal_d = dec_illegal;
                    sa_d      = dec.src_a;
                    sb_d      = dec.src_b;
                    sc_d      = dec.dest;
                    op_d      = dec.op;
                    rf_d      = dec.clr_flags;
                end
            end
            DECODE: begin
                if (illegal_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    state_d = EXEC;
                    hab_d   = 1'b1;
                end
            end
            EXEC: begin
                if (rep_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    rep_d = rep_q - 1'b1;
                    hab_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            CLR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counter and output registers; reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            rep_q     <= '0;
            illegal_q <= 1'b0;
            sa_q      <= '0;
            sb_q      <= '0;
            sc_q      <= '0;
            op_q      <= '0;
            hab_q     <= 1'b0;
            rf_q      <= 1'b0;
            rb_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rep_q     <= rep_d;
            illegal_q <= illegal_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            sc_q      <= sc_d;
            op_q      <= op_d;
            hab_q     <= hab_d;
            rf_q      <= rf_d;
            rb_q      <= rb_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_bloco_sequenciador.sv
// Purpose: scoreboard bench for the BLOCO sequencer with randomized instructions.
// Latency: checks accept-to-done distance and write window for every instruction.
// Backpressure: source holds the word until ready, also while the DUT is busy.
module tb_bloco_sequenciador;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr_word = '0;
    logic        clear_bank = 1'b0;
    logic        Hab_Escrita;
    logic [1:0]  Sel_SA, Sel_SB, Sel_SC;
    logic [4:0]  controleOperacao;
    logic        reset_Flags, reset_Ban_Registros, busy, done, err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic       err;
        int         writes;
        int         lat;
        logic       rf;
        logic [1:0] a, b, c;
        logic [4:0] op;
        int         rep;
    } exp_t;

    exp_t sb_q[$];
    logic sb_en = 1'b1;

    bloco_sequenciador dut (
        .clk                 (clk),
        .reset               (reset),
        .instr_valid         (instr_valid),
        .instr_ready         (instr_ready),
        .instr_word          (instr_word),
        .clear_bank          (clear_bank),
        .Hab_Escrita         (Hab_Escrita),
        .Sel_SA              (Sel_SA),
        .Sel_SB              (Sel_SB),
        .Sel_SC              (Sel_SC),
        .controleOperacao    (controleOperacao),
        .reset_Flags         (reset_Flags),
        .reset_Ban_Registros (reset_Ban_Registros),
        .busy                (busy),
        .done                (done),
        .err                 (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [15:0] mk(input bit clr, input int op, input int d,
                                       input int a, input int b, input int rep);
        logic [15:0] w;
        w = {clr, 5'(op), 2'(d), 2'(a), 2'(b), 4'(rep)};
        return w;
    endfunction

    // Reference model: what a single instruction must do, from its fields alone.
    function automatic exp_t model(input logic [15:0] w);
        exp_t e;
        int   op;
        op       = int'(w[14:10]);
        e.rep    = int'(w[3:0]);
        e.err    = (op >= 20);
        e.writes = e.err ? 0 : e.rep + 1;
        e.lat    = e.err ? 2 : e.rep + 3;
        e.rf     = w[15];
        e.c      = w[9:8];
        e.a      = w[7:6];
        e.b      = w[5:4];
        e.op     = w[14:10];
        return e;
    endfunction

    // Present a word, hold it until accepted, optionally register the expectation.
    task automatic send(input logic [15:0] w, input bit push);
        bit ok = 0;
        instr_word  = w;
        instr_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (instr_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            check("accept_timeout", 0, 1);
        end else if (push) begin
            sb_q.push_back(model(w));
        end
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    // Monitor: tracks each accepted instruction and compares on the done pulse.
    int   acc_cyc = 0;
    int   wr_cnt = 0;
    int   rf_cnt = 0;
    logic in_flight = 1'b0;
    logic chk_idle = 1'b0;

    always @(negedge clk) begin
        if (!sb_en || !reset) begin
            in_flight = 1'b0;
            chk_idle  = 1'b0;
        end else begin
            if (chk_idle) begin
                check("idle_after_done_busy", int'(busy), 0);
                check("idle_after_done_ready", int'(instr_ready), int'(!clear_bank));
                chk_idle = 1'b0;
            end
            if (instr_valid && instr_ready) begin
                acc_cyc   = cyc;
                wr_cnt    = 0;
                rf_cnt    = 0;
                in_flight = 1'b1;
            end
            if (Hab_Escrita) begin
                wr_cnt++;
                if (!in_flight || sb_q.size() == 0) begin
                    check("write_without_instr", 1, 0);
                end else begin
                    check("write_window",
                          int'((cyc - acc_cyc >= 2) && (cyc - acc_cyc <= 2 + sb_q[0].rep)), 1);
                    check("write_sels", int'({Sel_SA, Sel_SB, Sel_SC, controleOperacao}),
                          int'({sb_q[0].a, sb_q[0].b, sb_q[0].c, sb_q[0].op}));
                end
            end
            if (reset_Flags) begin
                rf_cnt++;
                check("flags_in_decode", cyc - acc_cyc, 1);
            end
            if (reset_Ban_Registros && in_flight)
                check("bank_clear_during_instr", 1, 0);
            if (err && !done)
                check("err_without_done", 1, 0);
            if (done) begin
                if (!in_flight || sb_q.size() == 0) begin
                    check("done_without_instr", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("done_latency", cyc - acc_cyc, e.lat);
                    check("done_err", int'(err), int'(e.err));
                    check("write_count", wr_cnt, e.writes);
                    check("flag_pulses", rf_cnt, int'(e.rf));
                    check("held_sels", int'({Sel_SA, Sel_SB, Sel_SC, controleOperacao}),
                          int'({e.a, e.b, e.c, e.op}));
                    chk_idle = 1'b1;
                end
                in_flight = 1'b0;
            end
        end
    end

    initial begin
        // Reset held two cycles with a valid word offered: nothing accepted.
        reset       = 1'b0;
        instr_valid = 1'b1;
        instr_word  = mk(0, 0, 2, 1, 3, 0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_ready", int'(instr_ready), 1);
            check("rst_busy", int'(busy), 0);
            check("rst_outputs", int'({Hab_Escrita, done, err, reset_Flags, reset_Ban_Registros,
                                       Sel_SA, Sel_SB, Sel_SC, controleOperacao}), 0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        send(mk(0, 0, 2, 1, 3, 0), 1);
        #1 check("busy_after_accept", int'(busy), 1);

        // Long chained instruction, illegal opcode, flag clear.
        send(mk(0, 3, 0, 0, 2, 15), 1);
        send(mk(0, 25, 1, 2, 3, 7), 1);
        send(mk(1, 5, 3, 1, 0, 2), 1);

        // clear_bank together with a valid word: clear first, accept right after.
        for (int i = 0; i < 40 && busy; i++) @(posedge clk);
        #1;
        clear_bank  = 1'b1;
        instr_valid = 1'b1;
        instr_word  = mk(1, 7, 2, 2, 1, 1);
        @(negedge clk);
        check("clr_ready_low", int'(instr_ready), 0);
        @(posedge clk);
        #1 clear_bank = 1'b0;
        @(negedge clk);
        check("clr_pulse", int'(reset_Ban_Registros), 1);
        check("clr_busy", int'(busy), 1);
        send(mk(1, 7, 2, 2, 1, 1), 1);
        #1 check("clr_pulse_one_cycle", int'(reset_Ban_Registros), 0);

        // Reset in the middle of a rep=8 instruction aborts it silently.
        for (int i = 0; i < 40 && (busy || sb_q.size() != 0); i++) @(posedge clk);
        @(posedge clk);
        #1 sb_en = 1'b0;
        send(mk(0, 4, 1, 1, 1, 8), 0);
        for (int i = 0; i < 4; i++) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_hab", int'(Hab_Escrita), 0);
        check("abort_busy", int'(busy), 0);
        @(posedge clk);
        #1 reset = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (done || Hab_Escrita) seen++;
            end
            check("abort_no_activity", seen, 0);
        end
        @(posedge clk);
        #1 sb_en = 1'b1;

        // Randomized traffic; the next word is offered while the DUT is still busy.
        for (int n = 0; n < 40; n++) begin
            int gap;
            send(mk($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15)), 1);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) @(posedge clk);
            #1;
        end

        for (int i = 0; i < 500 && sb_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
